// File: rtl/pe_pkg.sv
// Shared constants and state type for the PE address/mode sequencer.
// Optional GEN_COUNT_EN adds a generation counter port on pe_sequencer.
package pe_pkg;

  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 10;

  localparam logic [1:0] INIT_MODE        = 2'd0;
  localparam logic [1:0] VGA_MODE         = 2'd1;
  localparam logic [1:0] COLLISION_MODE   = 2'd2;
  localparam logic [1:0] PROPAGATION_MODE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    COLLIDE,
    TURN,
    PROP,
    DONE
  } state_e;

endpackage

// File: rtl/pe_sequencer_sweep.sv
// Sweep index generator shared by the init, collision and propagation passes.
// Outputs describe the next cycle so the top can register them.
module sweep_counter #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int K_W    = ADDR_W + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              en,
  input  logic [K_W-1:0]    lag,
  output logic [ADDR_W-1:0] rd_idx,
  output logic [ADDR_W-1:0] wr_idx,
  output logic              wr_stb,
  output logic              last
);

  localparam logic [K_W-1:0] LAST_RD = K_W'(DEPTH - 1);

  logic [K_W-1:0] k_q, k_d;
  logic [K_W-1:0] lag_q, lag_d;
  logic [K_W-1:0] wr_k;

  always_comb begin
    lag_d = start ? lag : lag_q;
    k_d   = k_q;
    if (start)   k_d = '0;
    else if (en) k_d = k_q + K_W'(1);
    wr_k   = k_d - lag_d;
    rd_idx = (k_d > LAST_RD) ? ADDR_W'(LAST_RD)
                             : k_d[ADDR_W-1:0];
    wr_idx = wr_k[ADDR_W-1:0];
    wr_stb = en && (k_d >= lag_d) && (wr_k <= LAST_RD);
    // last refers to the cycle currently on the outputs
    last   = (k_q == LAST_RD + lag_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q   <= '0;
      lag_q <= '0;
    end else begin
      k_q   <= k_d;
      lag_q <= lag_d;
    end
  end

endmodule

// File: rtl/pe_sequencer.sv
// Mode/address sequencer for the PE columns: init, collision, propagation.
// Define GEN_COUNT_EN to add the gen_count output.
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int COLL_LAG = 1,
  parameter int PROP_LAG = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_start,
  input  logic              run,
  input  logic              step,
  input  logic              vga_blank,
  input  logic [ADDR_W-1:0] vga_read_addr,
  output logic [ADDR_W-1:0] init_addr,
  output logic [1:0]        mode,
  output logic              pe_we,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic              busy,
  output logic              init_done,
  output logic              gen_done,
`ifdef GEN_COUNT_EN
  output logic [15:0]       gen_count,
`endif
  output logic              vga_overrun
);

  localparam int K_W = ADDR_W + 2;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              pend_q, pend_d;
  logic              blank_q;
  logic              ovr_q, ovr_d;
  logic              idone_q, idone_d;
  logic              gdone_q, gdone_d;

  logic              sc_start, sc_en, sc_stb, sc_last;
  logic [K_W-1:0]    sc_lag;
  logic [ADDR_W-1:0] sc_rd, sc_wr;
  logic              in_gen;

  sweep_counter #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .K_W   (K_W)
  ) u_sweep (
    .clk   (clk),
    .reset (reset),
    .start (sc_start),
    .en    (sc_en),
    .lag   (sc_lag),
    .rd_idx(sc_rd),
    .wr_idx(sc_wr),
    .wr_stb(sc_stb),
    .last  (sc_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (init_start)
          state_d = INIT;
        else if ((run || pend_q) && vga_blank)
          state_d = COLLIDE;
      end
      INIT:    if (sc_last) state_d = IDLE;
      COLLIDE: if (sc_last) state_d = TURN;
      TURN:    state_d = PROP;
      PROP:    if (sc_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sc_en    = (state_d == INIT) || (state_d == COLLIDE)
            || (state_d == PROP);
    sc_start = sc_en && (state_d != state_q);
    sc_lag   = (state_d == PROP)    ? K_W'(PROP_LAG)
             : (state_d == COLLIDE) ? K_W'(COLL_LAG)
             :                        K_W'(1);

    mode_d = VGA_MODE;
    unique case (state_d)
      INIT:          mode_d = INIT_MODE;
      COLLIDE, TURN: mode_d = COLLISION_MODE;
      PROP:          mode_d = PROPAGATION_MODE;
      default:       mode_d = VGA_MODE;
    endcase

    we_d = sc_stb;
    wa_d = sc_stb ? sc_wr : wa_q;
    // TURN pre-reads word 0 so PROP sees valid data on its first cycle
    rd_d = sc_en ? sc_rd
         : (state_d == TURN) ? '0 : rd_q;

    pend_d = step | (pend_q & ~((state_d == COLLIDE)
                             && (state_q != COLLIDE)));
    in_gen = (state_q == COLLIDE) || (state_q == TURN)
          || (state_q == PROP);
    ovr_d   = ovr_q | (in_gen & blank_q & ~vga_blank);
    idone_d = (state_q == INIT) && (state_d == IDLE);
    gdone_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= VGA_MODE;
      we_q    <= 1'b0;
      wa_q    <= '0;
      rd_q    <= '0;
      pend_q  <= 1'b0;
      blank_q <= 1'b0;
      ovr_q   <= 1'b0;
      idone_q <= 1'b0;
      gdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      blank_q <= vga_blank;
      ovr_q   <= ovr_d;
      idone_q <= idone_d;
      gdone_q <= gdone_d;
    end
  end

`ifdef GEN_COUNT_EN
  logic [15:0] gcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      gcnt_q <= '0;
    else if (state_q == DONE)
      gcnt_q <= gcnt_q + 16'd1;
  end

  assign gen_count = gcnt_q;
`endif

  assign mode        = mode_q;
  assign pe_we       = we_q;
  assign write_addr  = wa_q;
  assign read_addr   = (state_q == IDLE) ? vga_read_addr : rd_q;
  assign init_addr   = rd_q;
  assign busy        = (state_q != IDLE);
  assign init_done   = idone_q;
  assign gen_done    = gdone_q;
  assign vga_overrun = ovr_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer with default parameters.
module tb_pe_sequencer;

  localparam int AW = 10;
  localparam int D  = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init_start = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          vga_blank = 1'b0;
  logic [AW-1:0] vga_read_addr = '0;
  logic [AW-1:0] init_addr;
  logic [1:0]    mode;
  logic          pe_we;
  logic [AW-1:0] write_addr;
  logic [AW-1:0] read_addr;
  logic          busy;
  logic          init_done;
  logic          gen_done;
  logic          vga_overrun;
`ifdef GEN_COUNT_EN
  logic [15:0]   gen_count;
`endif

  pe_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .init_start   (init_start),
    .run          (run),
    .step         (step),
    .vga_blank    (vga_blank),
    .vga_read_addr(vga_read_addr),
    .init_addr    (init_addr),
    .mode         (mode),
    .pe_we        (pe_we),
    .write_addr   (write_addr),
    .read_addr    (read_addr),
    .busy         (busy),
    .init_done    (init_done),
    .gen_done     (gen_done),
`ifdef GEN_COUNT_EN
    .gen_count    (gen_count),
`endif
    .vga_overrun  (vga_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]    m;
    logic [AW-1:0] a;
  } wr_t;

  wr_t           sb[$];
  logic [AW-1:0] rd_hist[0:2199];

  task automatic test_reset();
    reset = 1'b0;
    vga_read_addr = 10'h155;
    repeat (3) @(negedge clk);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL reset_mode got=%0d exp=1", mode);
    end
    checks++;
    if (pe_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_we got=%b exp=0", pe_we);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (read_addr !== 10'h155) begin
      errors++;
      $display("FAIL reset_rdpass got=%h exp=155", read_addr);
    end
    checks++;
    if ({init_done, gen_done, vga_overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000",
               {init_done, gen_done, vga_overrun});
    end
    checks++;
    if (write_addr !== '0) begin
      errors++;
      $display("FAIL reset_waddr got=%0d exp=0", write_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vga_read_addr = 10'h2aa;
    #1;
    checks++;
    if (read_addr !== 10'h2aa) begin
      errors++;
      $display("FAIL idle_rdpass got=%h exp=2aa", read_addr);
    end
  endtask

  task automatic test_init();
    int nwe;
    int ndone;
    logic [AW-1:0] prev_ia;
    wr_t e;
    nwe = 0;
    ndone = 0;
    @(negedge clk);
    init_start = 1'b1;
    for (int i = 0; i < D; i++) sb.push_back({2'd0, AW'(i)});
    @(negedge clk);
    init_start = 1'b0;
    prev_ia = init_addr;
    for (int c = 0; c < 1030; c++) begin
      if (busy) begin
        checks++;
        if (mode !== 2'd0) begin
          errors++;
          $display("FAIL init_mode c=%0d got=%0d exp=0", c, mode);
        end
      end
      if (pe_we) begin
        nwe++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL init_extra_we c=%0d got=%0d exp=none",
                   c, write_addr);
        end else begin
          e = sb.pop_front();
          if (write_addr !== e.a) begin
            errors++;
            $display("FAIL init_waddr got=%0d exp=%0d",
                     write_addr, e.a);
          end
        end
        checks++;
        if (write_addr !== prev_ia) begin
          errors++;
          $display("FAIL init_lag got=%0d exp=%0d",
                   write_addr, prev_ia);
        end
      end
      if (init_done) ndone++;
      prev_ia = init_addr;
      @(negedge clk);
    end
    checks++;
    if (nwe != D) begin
      errors++;
      $display("FAIL init_we_count got=%0d exp=%0d", nwe, D);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL init_done_count got=%0d exp=1", ndone);
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL init_end left=%0d busy=%b exp=0/0",
               sb.size(), busy);
    end
    sb.delete();
  endtask

  task automatic test_step();
    int w;
    int nwe;
    int ngd;
    wr_t e;
    w = 0;
    nwe = 0;
    ngd = 0;
    vga_blank = 1'b1;
    run = 1'b0;
    @(negedge clk);
    step = 1'b1;
    for (int i = 0; i < D; i++) sb.push_back({2'd2, AW'(i)});
    for (int i = 0; i < D; i++) sb.push_back({2'd3, AW'(i)});
    @(negedge clk);
    step = 1'b0;
    while (mode !== 2'd2 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (mode !== 2'd2) begin
      errors++;
      $display("FAIL step_start got=%0d exp=2", mode);
    end
    for (int t = 0; t < 2100; t++) begin
      rd_hist[t] = read_addr;
      if (pe_we) begin
        nwe++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL gen_extra_we t=%0d got=%0d exp=none",
                   t, write_addr);
        end else begin
          e = sb.pop_front();
          if (mode !== e.m || write_addr !== e.a) begin
            errors++;
            $display("FAIL gen_write t=%0d got=%0d/%0d exp=%0d/%0d",
                     t, mode, write_addr, e.m, e.a);
          end
        end
        checks++;
        if (mode == 2'd2 && write_addr !== rd_hist[t-1]) begin
          errors++;
          $display("FAIL coll_lag t=%0d got=%0d exp=%0d",
                   t, write_addr, rd_hist[t-1]);
        end else if (mode == 2'd3 && write_addr !== rd_hist[t-2]) begin
          errors++;
          $display("FAIL prop_lag t=%0d got=%0d exp=%0d",
                   t, write_addr, rd_hist[t-2]);
        end
      end
      if (gen_done) begin
        ngd++;
        checks++;
        if (t != 2052) begin
          errors++;
          $display("FAIL gen_done_time got=%0d exp=2052", t);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ngd != 1) begin
      errors++;
      $display("FAIL gen_done_count got=%0d exp=1", ngd);
    end
    checks++;
    if (nwe != 2 * D) begin
      errors++;
      $display("FAIL gen_we_count got=%0d exp=%0d", nwe, 2 * D);
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gen_end left=%0d busy=%b exp=0/0",
               sb.size(), busy);
    end
    sb.delete();
  endtask

  task automatic test_blank_wait();
    int nbusy;
    int w;
    nbusy = 0;
    w = 0;
    vga_blank = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    checks++;
    if (nbusy != 0) begin
      errors++;
      $display("FAIL blank_hold got=%0d busy cycles exp=0", nbusy);
    end
    vga_blank = 1'b1;
    @(negedge clk);
    checks++;
    if (mode !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL blank_start got=%0d/%b exp=2/1", mode, busy);
    end
    while (!gen_done && w < 2100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w != 2052) begin
      errors++;
      $display("FAIL blank_gen_time got=%0d exp=2052", w);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vga_overrun !== 1'b0) begin
      errors++;
      $display("FAIL blank_end got=%b/%b exp=0/0", busy, vga_overrun);
    end
  endtask

  task automatic test_overrun();
    int w;
    int t;
    w = 0;
    vga_blank = 1'b1;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    while (mode !== 2'd2 && w < 10) begin
      @(negedge clk);
      w++;
    end
    repeat (1200) @(negedge clk);
    t = 1200;
    checks++;
    if (mode !== 2'd3) begin
      errors++;
      $display("FAIL ovr_in_prop got=%0d exp=3", mode);
    end
    vga_blank = 1'b0;
    @(negedge clk);
    t++;
    checks++;
    if (vga_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got=%b exp=1", vga_overrun);
    end
    while (!gen_done && t < 2200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != 2052) begin
      errors++;
      $display("FAIL ovr_gen_time got=%0d exp=2052", t);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (vga_overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_sticky got=%b/%b exp=1/0", vga_overrun, busy);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int ngd;
    int nb;
    w = 0;
    ngd = 0;
    nb = 0;
    vga_blank = 1'b1;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    while (mode !== 2'd2 && w < 10) begin
      @(negedge clk);
      w++;
    end
    repeat (500) @(negedge clk);
    checks++;
    if (pe_we !== 1'b1 || write_addr !== 10'd499) begin
      errors++;
      $display("FAIL mid_pre got=%b/%0d exp=1/499", pe_we, write_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pe_we !== 1'b0 || mode !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got=%b/%0d/%b exp=0/1/0",
               pe_we, mode, busy);
    end
    checks++;
    if (vga_overrun !== 1'b0 || write_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset_clr got=%b/%0d exp=0/0",
               vga_overrun, write_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2200) begin
      @(negedge clk);
      if (gen_done) ngd++;
      if (busy) nb++;
    end
    checks++;
    if (ngd != 0 || nb != 0) begin
      errors++;
      $display("FAIL mid_after got=%0d gen_done/%0d busy exp=0/0",
               ngd, nb);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_step();
    test_blank_wait();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
